// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and arbitrates next-fetch redirects.
// Optional branch delay slot: define DELAY_SLOT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        jr_req,
  input  logic [31:0] jr_addr,
  input  logic        j_req,
  input  logic [25:0] j_index,
  input  logic        br_req,
  input  logic [15:0] br_offset,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        redirect,
  output logic [2:0]  redirect_src
);

  localparam logic [2:0] SRC_SEQ  = 3'd0;
  localparam logic [2:0] SRC_EXC  = 3'd1;
  localparam logic [2:0] SRC_ERET = 3'd2;
  localparam logic [2:0] SRC_JR   = 3'd3;
  localparam logic [2:0] SRC_J    = 3'd4;
  localparam logic [2:0] SRC_BR   = 3'd5;

`ifdef DELAY_SLOT_EN
  typedef enum logic [1:0] {BOOT, RUN, HOLD, SLOT} state_e;
`else
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_e;
`endif

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_tgt_q;
  logic [2:0]  pend_src_q;
  logic        redir_q;
  logic [2:0]  src_q;

  logic [31:0] j_tgt;
  logic [31:0] br_tgt;
  logic [31:0] req_tgt;
  logic [2:0]  req_src;
  logic [31:0] win_tgt;
  logic [2:0]  win_src;

  assign pc_plus4     = pc_q + 32'd4;
  assign j_tgt        = {pc_plus4[31:28], j_index, 2'b00};
  assign br_tgt       = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign pc           = pc_q;
  assign redirect     = redir_q;
  assign redirect_src = src_q;
  assign fetch_valid  = (state_q != BOOT) && !stall;

  // Highest-priority non-exception request of this cycle
  always_comb begin
    req_src = SRC_SEQ;
    req_tgt = pc_plus4;
    if (eret_req) begin
      req_src = SRC_ERET;
      req_tgt = epc;
    end else if (jr_req) begin
      req_src = SRC_JR;
      req_tgt = jr_addr;
    end else if (j_req) begin
      req_src = SRC_J;
      req_tgt = j_tgt;
    end else if (br_req) begin
      req_src = SRC_BR;
      req_tgt = br_tgt;
    end
  end

  // Pending vs current request; pending keeps ties since it came first
  always_comb begin
    win_src = req_src;
    win_tgt = req_tgt;
    if (pend_src_q != SRC_SEQ &&
        (req_src == SRC_SEQ || pend_src_q <= req_src)) begin
      win_src = pend_src_q;
      win_tgt = pend_tgt_q;
    end
  end

  // PC, pending redirect and registered redirect status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_src_q <= SRC_SEQ;
      redir_q    <= 1'b0;
      src_q      <= SRC_SEQ;
    end else if (state_q == BOOT) begin
      state_q <= RUN;
    end else if (exc_req) begin
      state_q    <= RUN;
      pc_q       <= EXC_VECTOR;
      redir_q    <= 1'b1;
      src_q      <= SRC_EXC;
      pend_tgt_q <= '0;
      pend_src_q <= SRC_SEQ;
`ifdef DELAY_SLOT_EN
    end else if (state_q == SLOT) begin
      if (stall) begin
        if (eret_req) begin
          pend_tgt_q <= epc;
          pend_src_q <= SRC_ERET;
        end
      end else begin
        state_q    <= RUN;
        pc_q       <= eret_req ? epc : pend_tgt_q;
        redir_q    <= 1'b1;
        src_q      <= eret_req ? SRC_ERET : pend_src_q;
        pend_tgt_q <= '0;
        pend_src_q <= SRC_SEQ;
      end
`endif
    end else if (stall) begin
      state_q    <= HOLD;
      pend_tgt_q <= win_tgt;
      pend_src_q <= win_src;
    end else begin
`ifdef DELAY_SLOT_EN
      if (win_src >= SRC_JR) begin
        state_q    <= SLOT;
        pc_q       <= pc_plus4;
        redir_q    <= 1'b0;
        src_q      <= SRC_SEQ;
        pend_tgt_q <= win_tgt;
        pend_src_q <= win_src;
      end else begin
        state_q    <= RUN;
        pc_q       <= win_tgt;
        redir_q    <= (win_src != SRC_SEQ);
        src_q      <= win_src;
        pend_tgt_q <= '0;
        pend_src_q <= SRC_SEQ;
      end
`else
      state_q    <= RUN;
      pc_q       <= win_tgt;
      redir_q    <= (win_src != SRC_SEQ);
      src_q      <= win_src;
      pend_tgt_q <= '0;
      pend_src_q <= SRC_SEQ;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checks of pc_sequencer
// against a rule-level reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RST = 32'h0040_0000;
  localparam logic [31:0] EXC = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exc_req, eret_req, jr_req, j_req, br_req;
  logic [31:0] epc, jr_addr;
  logic [25:0] j_index;
  logic [15:0] br_offset;
  logic [31:0] pc, pc_plus4;
  logic        fetch_valid, redirect;
  logic [2:0]  redirect_src;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc, m_pt;
  logic        m_boot, m_redir, m_pv, m_slot;
  int          m_src, m_ps;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .jr_req(jr_req), .jr_addr(jr_addr),
    .j_req(j_req), .j_index(j_index),
    .br_req(br_req), .br_offset(br_offset),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid),
    .redirect(redirect), .redirect_src(redirect_src)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    stall = 0; exc_req = 0; eret_req = 0; jr_req = 0;
    j_req = 0; br_req = 0; epc = '0; jr_addr = '0;
    j_index = '0; br_offset = '0;
  endtask

  task automatic model_reset();
    m_pc = RST; m_boot = 1; m_redir = 0; m_src = 0;
    m_pv = 0; m_ps = 0; m_pt = '0; m_slot = 0;
  endtask

  // Next-state rules of the sequencer, applied to current inputs.
  task automatic model_tick();
    logic [31:0] p4, wt;
    logic [31:0] tg [1:5];
    bit act [1:5];
    int w, off;
    p4 = m_pc + 32'd4;
    off = $signed(br_offset);
    act[1] = exc_req; tg[1] = EXC;
    act[2] = eret_req; tg[2] = epc;
    act[3] = jr_req; tg[3] = jr_addr;
    act[4] = j_req; tg[4] = {p4[31:28], j_index, 2'b00};
    act[5] = br_req; tg[5] = p4 + 32'(off * 4);
    w = 0; wt = p4;
    for (int i = 2; i <= 5; i++)
      if (act[i] && w == 0) begin w = i; wt = tg[i]; end
    if (m_boot) begin
      m_boot = 0;
    end else if (exc_req) begin
      m_pc = EXC; m_redir = 1; m_src = 1;
      m_pv = 0; m_slot = 0;
    end else if (m_slot) begin
      if (stall) begin
        if (eret_req) begin m_pt = epc; m_ps = 2; end
      end else begin
        m_pc = eret_req ? epc : m_pt;
        m_src = eret_req ? 2 : m_ps;
        m_redir = 1; m_slot = 0;
      end
    end else begin
      if (m_pv && (w == 0 || m_ps <= w)) begin
        w = m_ps; wt = m_pt;
      end
      if (stall) begin
        if (w != 0) begin m_pv = 1; m_ps = w; m_pt = wt; end
      end else begin
        m_pv = 0;
        if (w == 0) begin
          m_pc = p4; m_redir = 0; m_src = 0;
`ifdef DELAY_SLOT_EN
        end else if (w >= 3) begin
          m_pc = p4; m_redir = 0; m_src = 0;
          m_slot = 1; m_pt = wt; m_ps = w;
`endif
        end else begin
          m_pc = wt; m_redir = 1; m_src = w;
        end
      end
    end
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    clear_in();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    checks++;
    if (pc !== RST || redirect !== 1'b0 || redirect_src !== 3'd0) begin
      errors++;
      $display("FAIL reset_async pc=%h red=%b src=%0d want %h 0 0",
               pc, redirect, redirect_src, RST);
    end
    apply_reset();
    checks++;
    if (fetch_valid !== 1'b0 || pc !== RST) begin
      errors++;
      $display("FAIL boot fv=%b pc=%h want 0 %h", fetch_valid, pc, RST);
    end
    step();
    checks++;
    if (pc !== RST || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL boot_exit pc=%h fv=%b want %h 1", pc, fetch_valid, RST);
    end
    step();
    checks++;
    if (pc !== 32'h0040_0004) begin
      errors++;
      $display("FAIL seq1 pc=%h want 00400004", pc);
    end
    step();
    checks++;
    if (pc !== 32'h0040_0008 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL seq2 pc=%h red=%b want 00400008 0", pc, redirect);
    end
  endtask

  task automatic test_boot_exc();
    apply_reset();
    exc_req = 1;
    step();
    exc_req = 0;
    checks++;
    if (pc !== RST || redirect !== 1'b0) begin
      errors++;
      $display("FAIL boot_exc pc=%h red=%b want %h 0", pc, redirect, RST);
    end
    step();
    checks++;
    if (pc !== 32'h0040_0004 || redirect_src !== 3'd0) begin
      errors++;
      $display("FAIL boot_exc_seq pc=%h src=%0d want 00400004 0",
               pc, redirect_src);
    end
  endtask

  task automatic test_jump();
    step();
    step();
    j_req = 1; j_index = 26'h0100040;
    step();
    j_req = 0;
    checks++;
    if (pc !== 32'h0040_0100 || redirect !== 1'b1 || redirect_src !== 3'd4) begin
      errors++;
      $display("FAIL jump pc=%h red=%b src=%0d want 00400100 1 4",
               pc, redirect, redirect_src);
    end
    step();
    checks++;
    if (pc !== 32'h0040_0104 || redirect !== 1'b0 || redirect_src !== 3'd0) begin
      errors++;
      $display("FAIL jump_after pc=%h red=%b src=%0d want 00400104 0 0",
               pc, redirect, redirect_src);
    end
  endtask

  task automatic test_branch();
    jr_req = 1; jr_addr = 32'h0040_0020;
    step();
    jr_req = 0;
    checks++;
    if (pc !== 32'h0040_0020 || pc_plus4 !== 32'h0040_0024) begin
      errors++;
      $display("FAIL jr_setup pc=%h p4=%h want 00400020 00400024", pc, pc_plus4);
    end
    br_req = 1; br_offset = 16'hFFFE;
    step();
    br_req = 0;
    checks++;
    if (pc !== 32'h0040_001C || redirect_src !== 3'd5 || redirect !== 1'b1) begin
      errors++;
      $display("FAIL branch pc=%h src=%0d red=%b want 0040001c 5 1",
               pc, redirect_src, redirect);
    end
  endtask

  task automatic test_stall_hold();
    stall = 1;
    jr_req = 1; jr_addr = 32'h0040_0200;
    step();
    jr_req = 0;
    br_req = 1; br_offset = 16'h0010;
    checks++;
    if (pc !== 32'h0040_001C || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall1 pc=%h fv=%b want 0040001c 0", pc, fetch_valid);
    end
    step();
    br_req = 0;
    step();
    checks++;
    if (pc !== 32'h0040_001C || redirect !== 1'b1 || redirect_src !== 3'd5) begin
      errors++;
      $display("FAIL stall3 pc=%h red=%b src=%0d want 0040001c 1 5",
               pc, redirect, redirect_src);
    end
    stall = 0;
    step();
    checks++;
    if (pc !== 32'h0040_0200 || redirect_src !== 3'd3 || redirect !== 1'b1) begin
      errors++;
      $display("FAIL stall_release pc=%h src=%0d red=%b want 00400200 3 1",
               pc, redirect_src, redirect);
    end
  endtask

  task automatic test_exc_stall();
    stall = 1; jr_req = 1; jr_addr = 32'h0040_0800; exc_req = 1;
    step();
    exc_req = 0; jr_req = 0;
    checks++;
    if (pc !== EXC || redirect_src !== 3'd1 || redirect !== 1'b1) begin
      errors++;
      $display("FAIL exc_stall pc=%h src=%0d red=%b want %h 1 1",
               pc, redirect_src, redirect, EXC);
    end
    step();
    stall = 0;
    step();
    checks++;
    if (pc !== 32'h0040_0008 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL exc_drop_jr pc=%h red=%b want 00400008 0", pc, redirect);
    end
  endtask

  task automatic test_priority();
    eret_req = 1; epc = 32'h0040_0300;
    jr_req = 1; jr_addr = 32'h0040_0400;
    j_req = 1; j_index = 26'h0100080;
    br_req = 1; br_offset = 16'h0003;
    step();
    checks++;
    if (pc !== 32'h0040_0300 || redirect_src !== 3'd2) begin
      errors++;
      $display("FAIL prio_eret pc=%h src=%0d want 00400300 2", pc, redirect_src);
    end
    eret_req = 0;
    step();
    checks++;
    if (pc !== 32'h0040_0400 || redirect_src !== 3'd3) begin
      errors++;
      $display("FAIL prio_jr pc=%h src=%0d want 00400400 3", pc, redirect_src);
    end
    jr_req = 0;
    step();
    checks++;
    if (pc !== 32'h0040_0200 || redirect_src !== 3'd4) begin
      errors++;
      $display("FAIL prio_j pc=%h src=%0d want 00400200 4", pc, redirect_src);
    end
    j_req = 0;
    step();
    br_req = 0;
    checks++;
    if (pc !== 32'h0040_0210 || redirect_src !== 3'd5) begin
      errors++;
      $display("FAIL prio_br pc=%h src=%0d want 00400210 5", pc, redirect_src);
    end
  endtask

  task automatic test_wrap();
    jr_req = 1; jr_addr = 32'hFFFF_FFFC;
    step();
    jr_req = 0;
    checks++;
    if (pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_p4 p4=%h want 00000000", pc_plus4);
    end
    step();
    checks++;
    if (pc !== 32'h0 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL wrap pc=%h red=%b want 00000000 0", pc, redirect);
    end
  endtask

  task automatic test_reset_mid_pending();
    stall = 1; jr_req = 1; jr_addr = 32'h0000_0500;
    step();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (pc !== RST || redirect !== 1'b0 || redirect_src !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid pc=%h red=%b src=%0d want %h 0 0",
               pc, redirect, redirect_src, RST);
    end
    apply_reset();
    step();
    step();
    checks++;
    if (pc !== 32'h0040_0004 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush pc=%h red=%b want 00400004 0", pc, redirect);
    end
  endtask

`ifdef DELAY_SLOT_EN
  task automatic test_delay_slot();
    apply_reset();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (pc !== 32'h0040_0010) begin
      errors++;
      $display("FAIL ds_setup pc=%h want 00400010", pc);
    end
    j_req = 1; j_index = 26'h0100040;
    step();
    j_index = 26'h0200000;
    checks++;
    if (pc !== 32'h0040_0014 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL ds_slot pc=%h red=%b want 00400014 0", pc, redirect);
    end
    step();
    j_req = 0;
    checks++;
    if (pc !== 32'h0040_0100 || redirect !== 1'b1 || redirect_src !== 3'd4) begin
      errors++;
      $display("FAIL ds_target pc=%h red=%b src=%0d want 00400100 1 4",
               pc, redirect, redirect_src);
    end
    step();
    checks++;
    if (pc !== 32'h0040_0104 || redirect !== 1'b0) begin
      errors++;
      $display("FAIL ds_ignore pc=%h red=%b want 00400104 0", pc, redirect);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      stall    = ($urandom_range(0, 3) == 0);
      exc_req  = ($urandom_range(0, 31) == 0);
      eret_req = ($urandom_range(0, 11) == 0);
      jr_req   = ($urandom_range(0, 5) == 0);
      j_req    = ($urandom_range(0, 5) == 0);
      br_req   = ($urandom_range(0, 5) == 0);
      epc      = {$urandom(), 2'b00} >> 0;
      epc[1:0] = 2'b00;
      jr_addr  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                              : ($urandom() & 32'hFFFF_FFFC);
      j_index  = 26'($urandom());
      br_offset = 16'($urandom());
      step();
      checks++;
      if (pc !== m_pc || pc_plus4 !== m_pc + 32'd4 ||
          redirect !== m_redir || redirect_src !== 3'(m_src) ||
          fetch_valid !== (!m_boot && !stall)) begin
        errors++;
        $display("FAIL rand%0d pc=%h red=%b src=%0d fv=%b want %h %b %0d %b",
                 n, pc, redirect, redirect_src, fetch_valid,
                 m_pc, m_redir, m_src, !m_boot && !stall);
      end
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    model_reset();
    rst_n = 1;
    #2;
    test_reset();
`ifdef DELAY_SLOT_EN
    test_delay_slot();
`else
    test_jump();
    test_branch();
    test_stall_hold();
    test_exc_stall();
    test_priority();
    test_wrap();
    test_boot_exc();
    test_reset_mid_pending();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
